// File: rtl/fmul_fp32_if.sv
// fmul_fp32_if: operand/result bundle for the fmul_fp32 multiplier.
//   valid_in  : a/b hold an operand pair this cycle
//   a, b      : binary32 operands
//   valid_out : z holds the product of the pair accepted 2 cycles earlier
//   z         : binary32 product
// master = producer of operands / consumer of results; slave = multiplier.
interface fmul_fp32_if;
  logic        valid_in;
  logic [31:0] a;
  logic [31:0] b;
  logic        valid_out;
  logic [31:0] z;

  modport master (output valid_in, a, b, input valid_out, z);
  modport slave  (input valid_in, a, b, output valid_out, z);
endinterface

// File: rtl/fmul_fp32.sv
// fmul_fp32: 2-stage pipelined binary32 multiplier, round-to-nearest-even,
// subnormals flushed to zero, canonical quiet NaN 0x7FC00000 for invalid ops.
//   clk  : rising-edge clock
//   rst  : asynchronous active-high reset (clears all pipeline state)
//   bus  : fmul_fp32_if.slave (valid_in, a, b in; valid_out, z out)
// Stage 1 registers sign, exponent sum, raw 48-bit product and the
// special-case decision; stage 2 normalizes, rounds and packs z.
module fmul_fp32 (
  input  logic          clk,
  input  logic          rst,
  fmul_fp32_if.slave    bus
);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  // ---------------- stage 1: unpack, classify, multiply ----------------
  logic [7:0]  ea, eb;
  logic [22:0] fa, fb;
  logic        zero_a, zero_b, inf_a, inf_b, nan_a, nan_b;
  logic        s_d;
  logic        special_d;
  logic [31:0] spz_d;
  logic signed [9:0] e_d;
  logic [47:0] prod_d;

  logic        v1_q;
  logic        s1_q;
  logic        special1_q;
  logic [31:0] spz1_q;
  logic signed [9:0] e1_q;
  logic [47:0] prod1_q;

  always_comb begin
    ea     = bus.a[30:23];
    eb     = bus.b[30:23];
    fa     = bus.a[22:0];
    fb     = bus.b[22:0];
    zero_a = (ea == 8'h00);
    zero_b = (eb == 8'h00);
    inf_a  = (ea == 8'hFF) && (fa == '0);
    inf_b  = (eb == 8'hFF) && (fb == '0);
    nan_a  = (ea == 8'hFF) && (fa != '0);
    nan_b  = (eb == 8'hFF) && (fb != '0);
    s_d    = bus.a[31] ^ bus.b[31];

    special_d = 1'b1;
    spz_d     = '0;
    if (nan_a || nan_b) begin
      spz_d = QNAN;
    end else if ((inf_a && zero_b) || (zero_a && inf_b)) begin
      spz_d = QNAN;
    end else if (inf_a || inf_b) begin
      spz_d = {s_d, 8'hFF, 23'h0};
    end else if (zero_a || zero_b) begin
      spz_d = {s_d, 8'h00, 23'h0};
    end else begin
      special_d = 1'b0;
    end

    // Biased result exponent before normalization; 10 signed bits cover
    // 1+1-127 = -125 up to 254+254-127+2 = 383.
    e_d    = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
    prod_d = 48'({1'b1, fa}) * 48'({1'b1, fb});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1_q       <= 1'b0;
      s1_q       <= 1'b0;
      special1_q <= 1'b0;
      spz1_q     <= '0;
      e1_q       <= '0;
      prod1_q    <= '0;
    end else begin
      v1_q       <= bus.valid_in;
      s1_q       <= s_d;
      special1_q <= special_d;
      spz1_q     <= spz_d;
      e1_q       <= e_d;
      prod1_q    <= prod_d;
    end
  end

  // ---------------- stage 2: normalize, round, pack ----------------
  logic [23:0] mant;
  logic        guard, sticky;
  logic signed [9:0] e_n, e_f;
  logic [24:0] mant_r;
  logic [22:0] frac;
  logic [31:0] z_d;

  logic        v2_q;
  logic [31:0] z_q;

  always_comb begin
    if (prod1_q[47]) begin
      mant   = prod1_q[47:24];
      guard  = prod1_q[23];
      sticky = |prod1_q[22:0];
      e_n    = e1_q + 10'sd1;
    end else begin
      mant   = prod1_q[46:23];
      guard  = prod1_q[22];
      sticky = |prod1_q[21:0];
      e_n    = e1_q;
    end

    // Ties-to-even: round up when above half, or exactly half with odd LSB.
    mant_r = {1'b0, mant} + 25'(guard & (sticky | mant[0]));

    // Carry out means the significand became exactly 2.0.
    if (mant_r[24]) begin
      frac = mant_r[23:1];
      e_f  = e_n + 10'sd1;
    end else begin
      frac = mant_r[22:0];
      e_f  = e_n;
    end

    if (special1_q) begin
      z_d = spz1_q;
    end else if (e_f >= 10'sd255) begin
      z_d = {s1_q, 8'hFF, 23'h0};
    end else if (e_f <= 10'sd0) begin
      z_d = {s1_q, 8'h00, 23'h0};
    end else begin
      z_d = {s1_q, e_f[7:0], frac};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2_q <= 1'b0;
      z_q  <= '0;
    end else begin
      v2_q <= v1_q;
      z_q  <= z_d;
    end
  end

  assign bus.valid_out = v2_q;
  assign bus.z         = z_q;

endmodule

// File: tb/tb_fmul_fp32.sv
module tb_fmul_fp32;

  logic clk;
  logic rst;
  int   errors;
  int   checks;
  int unsigned cyc;

  fmul_fp32_if bus ();

  fmul_fp32 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    logic [31:0] z;
    int unsigned cyc;
    string       tag;
  } exp_t;

  exp_t sb[$];

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks = checks + 1;
    if (act !== exp) begin
      errors = errors + 1;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  // Drive one operand pair for one cycle (just after a rising edge) and
  // record the expected product for the scoreboard.
  task automatic issue(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
    exp_t e;
    bus.valid_in = 1'b1;
    bus.a        = a;
    bus.b        = b;
    e.z   = exp;
    e.cyc = cyc;
    e.tag = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.valid_in = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: compare every valid result against the head of the scoreboard,
  // including the 2-cycle latency.
  always @(negedge clk) begin
    if (!rst && bus.valid_out === 1'b1) begin
      if (sb.size() == 0) begin
        check_eq("unexpected_valid", {31'b0, bus.valid_out}, 32'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        check_eq(e.tag, bus.z, e.z);
        check_eq({e.tag, "_lat"}, 32'(cyc - e.cyc), 32'd2);
      end
    end
  end

  initial begin
    errors = 0;
    checks = 0;
    cyc    = 0;
    bus.valid_in = 1'b0;
    bus.a = '0;
    bus.b = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_valid", {31'b0, bus.valid_out}, 32'd0);
    check_eq("rst_z", bus.z, 32'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    issue("zero",      32'h00000000, 32'h00000000, 32'h00000000);
    idle(3);

    // back-to-back basic products
    issue("2x4",       32'h40000000, 32'h40800000, 32'h41000000);
    issue("4x3",       32'h40800000, 32'h40400000, 32'h41400000);
    issue("one",       32'h3F800000, 32'h3F800000, 32'h3F800000);
    // rounding
    issue("sticky_dn", 32'h3F800001, 32'h3F800001, 32'h3F800002);
    issue("neg2p25",   32'h3FC00000, 32'hBFC00000, 32'hC0100000);
    issue("tie_up",    32'h3FC00000, 32'h3F800001, 32'h3FC00002);
    issue("tie_even",  32'h3FC00000, 32'h3F800003, 32'h3FC00004);
    // specials
    issue("inf_x_0",   32'h7F800000, 32'h00000000, 32'h7FC00000);
    issue("0_x_inf",   32'h00000000, 32'hFF800000, 32'h7FC00000);
    issue("ninf_x_2",  32'hFF800000, 32'h40000000, 32'hFF800000);
    issue("ninf_inf",  32'hFF800000, 32'h7F800000, 32'hFF800000);
    issue("nan_a",     32'h7FC00001, 32'h3F800000, 32'h7FC00000);
    issue("nan_b",     32'h3F800000, 32'hFF800001, 32'h7FC00000);
    issue("subnorm",   32'h00000001, 32'h3F800000, 32'h00000000);
    issue("negzero",   32'h80000000, 32'h40A00000, 32'h80000000);
    // range limits
    issue("ovf",       32'h7F000000, 32'h40000000, 32'h7F800000);
    issue("max_exp",   32'h7F000000, 32'h3F800000, 32'h7F000000);
    issue("unf",       32'h00800000, 32'h3F000000, 32'h00000000);
    issue("unf_neg",   32'h80800000, 32'h3F000000, 32'h80000000);
    issue("min_norm",  32'h00800000, 32'h3F800000, 32'h00800000);
    idle(4);

    // Reset mid-operation: first result lands, second is in flight.
    issue("pre_rst",   32'h40000000, 32'h40400000, 32'h40C00000);
    bus.valid_in = 1'b1;
    bus.a = 32'h40800000;
    bus.b = 32'h40800000;
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("midrst_valid", {31'b0, bus.valid_out}, 32'd0);
    check_eq("midrst_z", bus.z, 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(4);
    issue("post_rst",  32'h40400000, 32'h40400000, 32'h41100000);
    idle(1);

    // Bounded drain of anything still outstanding.
    for (int i = 0; i < 10 && sb.size() != 0; i++) begin
      @(posedge clk);
      #1;
    end
    check_eq("drain", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
